// File: rtl/present_decrypt_core_pkg.sv
// Shared PRESENT-80 constants, FSM encoding and 4-bit S-box tables.
package present_decrypt_core_pkg;

   localparam int unsigned ROUNDS = 31;
   localparam int unsigned KEY_W  = 80;
   localparam int unsigned BLK_W  = 64;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KEYFWD = 3'd1,
      ST_WHITEN = 3'd2,
      ST_DECR   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step: forward update (dir_inv=0) or its exact inverse (dir_inv=1).
module present_key_step
   import present_decrypt_core_pkg::*;
(
   input  logic             dir_inv,
   input  logic [CNT_W-1:0] round_idx,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] key_out_c
);

   logic [KEY_W-1:0] fwd_c;
   logic [KEY_W-1:0] unmix_c;
   logic [KEY_W-1:0] inv_c;

   always_comb begin
      fwd_c          = {key_in[18:0], key_in[KEY_W-1:19]};
      fwd_c[79:76]   = sbox(fwd_c[79:76]);
      fwd_c[19:15]   = fwd_c[19:15] ^ round_idx;

      // Undo the counter XOR and S-box before rotating back.
      unmix_c        = key_in;
      unmix_c[19:15] = unmix_c[19:15] ^ round_idx;
      unmix_c[79:76] = sbox_inv(unmix_c[79:76]);
      inv_c          = {unmix_c[60:0], unmix_c[KEY_W-1:61]};

      key_out_c      = dir_inv ? inv_c : fwd_c;
   end

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption: forward key schedule to K32, then one inverse round per clock.
module present_decrypt_core
   import present_decrypt_core_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_in,
   input  logic [BLK_W-1:0]  ciphertext,
   input  logic [KEY_W-1:0]  key,
   output logic              ready_out,
   output logic              valid_out,
   input  logic              ack_in,
   output logic [BLK_W-1:0]  plaintext,
   output logic              busy
);

   state_e            fsm_q,   fsm_d;
   logic [BLK_W-1:0]  data_q,  data_d;
   logic [KEY_W-1:0]  key_q,   key_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [BLK_W-1:0]  pt_q,    pt_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              busy_q,  busy_d;
   logic [KEY_W-1:0]  key_nxt_c;
   logic [BLK_W-1:0]  round_c;

   // Inverse pLayer: output bit j takes input bit P(j)=16*(j mod 4)+j/4 (P(63)=63).
   function automatic logic [BLK_W-1:0] p_inv_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int unsigned j = 0; j < BLK_W; j++) begin
         y[6'(j)] = x[6'(16 * (j % 4) + j / 4)];
      end
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] s_inv_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int unsigned n = 0; n < BLK_W / 4; n++) begin
         y[6'(4 * n) +: 4] = sbox_inv(x[6'(4 * n) +: 4]);
      end
      return y;
   endfunction

   present_key_step u_key_step (
      .dir_inv   (fsm_q == ST_DECR),
      .round_idx (cnt_q),
      .key_in    (key_q),
      .key_out_c (key_nxt_c)
   );

   always_comb begin
      round_c = s_inv_layer(p_inv_layer(data_q)) ^ key_nxt_c[KEY_W-1:16];
   end

   // Next-state and datapath update.
   always_comb begin
      fsm_d  = fsm_q;
      data_d = data_q;
      key_d  = key_q;
      cnt_d  = cnt_q;
      pt_d   = pt_q;
      case (fsm_q)
         ST_IDLE: begin
            if (enable_in) begin
               data_d = ciphertext;
               key_d  = key;
               cnt_d  = CNT_W'(1);
               fsm_d  = ST_KEYFWD;
            end
         end
         ST_KEYFWD: begin
            key_d = key_nxt_c;
            if (cnt_q == CNT_W'(ROUNDS)) begin
               fsm_d = ST_WHITEN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WHITEN: begin
            data_d = data_q ^ key_q[KEY_W-1:16];
            cnt_d  = CNT_W'(ROUNDS);
            fsm_d  = ST_DECR;
         end
         ST_DECR: begin
            key_d  = key_nxt_c;
            data_d = round_c;
            if (cnt_q == CNT_W'(1)) begin
               pt_d  = round_c;
               fsm_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (ack_in) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
      ready_d = (fsm_d == ST_IDLE);
      valid_d = (fsm_d == ST_DONE);
      busy_d  = (fsm_d == ST_KEYFWD) || (fsm_d == ST_WHITEN) || (fsm_d == ST_DECR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_q   <= ST_IDLE;
         data_q  <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         pt_q    <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         data_q  <= data_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         pt_q    <= pt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign ready_out = ready_q;
   assign valid_out = valid_q;
   assign busy      = busy_q;
   assign plaintext = pt_q;

endmodule

// File: tb/tb_present_decrypt_core.sv
// Scoreboard bench for present_decrypt_core: directed PRESENT-80 vectors plus encrypt-model round trips.
module tb_present_decrypt_core;
   import present_decrypt_core_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_in;
   logic        ack_in;
   logic [63:0] ciphertext;
   logic [79:0] key;
   logic [63:0] plaintext;
   logic        ready_out, valid_out, busy;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;
   logic        seen = 1'b0;

   logic [3:0]  SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam int          LAT    = 2 * ROUNDS + 1;

   present_decrypt_core dut (
      .clock      (clock),
      .reset      (reset),
      .enable_in  (enable_in),
      .ciphertext (ciphertext),
      .key        (key),
      .ready_out  (ready_out),
      .valid_out  (valid_out),
      .ack_in     (ack_in),
      .plaintext  (plaintext),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference encryption: K1 = user key, K(i+1) = update(K(i), i).
   function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [79:0] k_in);
      logic [63:0] s, t;
      logic [79:0] k;
      s = pt;
      k = k_in;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
         t = '0;
         for (int j = 0; j < 64; j++) t[16 * (j % 4) + j / 4] = s[j];
         s = t;
         k = {k[18:0], k[79:19]};
         k[79:76] = SB[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   // Monitor: one scoreboard pop per valid_out rising.
   always @(negedge clock) begin
      if (reset || !valid_out) begin
         seen = 1'b0;
      end else if (!seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 80'(valid_out), 80'(0));
         end else begin
            mon_exp = exp_q.pop_front();
            check("plaintext", 80'(plaintext), 80'(mon_exp));
         end
      end
   end

   task automatic run_req(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] exp,
                          input int inj_at, input int ack_delay, input bit ack_en);
      int n, busy_n, bad;
      bit got;
      n = 0;
      while (!ready_out && n < 200) begin
         @(posedge clock); #1; n++;
      end
      if (!ready_out) begin
         check("ready_wait", 80'(ready_out), 80'(1));
         return;
      end
      ciphertext = ct;
      key        = k;
      enable_in  = 1'b1;
      exp_q.push_back(exp);
      @(posedge clock); #1;
      enable_in  = 1'b0;
      ciphertext = {$urandom, $urandom};
      key        = {16'($urandom), $urandom, $urandom};
      busy_n     = busy ? 1 : 0;
      n          = 0;
      got        = 1'b0;
      while (n < 200 && !got) begin
         @(posedge clock); #1; n++;
         if (n == inj_at) begin
            enable_in  = 1'b1;
            ciphertext = {$urandom, $urandom};
         end else begin
            enable_in = 1'b0;
         end
         if (valid_out) got = 1'b1;
         else if (busy) busy_n++;
      end
      enable_in = 1'b0;
      if (!got) begin
         check("valid_timeout", 80'(got), 80'(1));
         exp_q.delete();
         return;
      end
      check("latency", 80'(n), 80'(LAT));
      check("busy_cycles", 80'(busy_n), 80'(LAT));
      bad = 0;
      repeat (ack_delay) begin
         @(posedge clock); #1;
         if (!valid_out || plaintext !== exp) bad++;
      end
      if (ack_delay > 0) check("hold_stable", 80'(bad), 80'(0));
      ack_in    = 1'b1;
      enable_in = ack_en;
      @(posedge clock); #1;
      ack_in    = 1'b0;
      enable_in = 1'b0;
      check("ack_valid_low", 80'(valid_out), 80'(0));
      check("ack_ready", 80'(ready_out), 80'(1));
      if (ack_en) begin
         check("pt_after_ack", 80'(plaintext), 80'(exp));
         @(posedge clock); #1;
         check("no_new_run_busy", 80'(busy), 80'(0));
         check("no_new_run_ready", 80'(ready_out), 80'(1));
      end
   endtask

   task automatic reset_mid_run();
      int bad;
      ciphertext = 64'h5579_C138_7B22_8445;
      key        = '0;
      enable_in  = 1'b1;
      @(posedge clock); #1;
      enable_in = 1'b0;
      repeat (39) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_ready", 80'(ready_out), 80'(1));
      check("abort_busy", 80'(busy), 80'(0));
      check("abort_valid", 80'(valid_out), 80'(0));
      bad = 0;
      repeat (80) begin
         @(posedge clock); #1;
         if (valid_out) bad++;
      end
      check("abort_no_valid", 80'(bad), 80'(0));
   endtask

   initial begin
      logic [63:0] pt, ct;
      logic [79:0] k;
      reset      = 1'b1;
      enable_in  = 1'b0;
      ack_in     = 1'b0;
      ciphertext = '0;
      key        = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", 80'(ready_out), 80'(1));
      check("rst_valid", 80'(valid_out), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_plaintext", 80'(plaintext), 80'(0));
      reset = 1'b0;

      run_req(64'h5579_C138_7B22_8445, 80'h0, 64'h0, 0, 0, 1'b0);
      run_req(64'hE72C_46C0_F594_5049, ONES80, 64'h0, 0, 0, 1'b0);
      run_req(64'hA112_FFC7_2F68_417B, 80'h0, ONES64, 0, 0, 1'b0);
      run_req(64'h3333_DCD3_2132_10D2, ONES80, ONES64, 0, 0, 1'b0);
      run_req(64'hE72C_46C0_F594_5049, ONES80, 64'h0, 40, 10, 1'b1);

      reset_mid_run();
      run_req(64'hA112_FFC7_2F68_417B, 80'h0, ONES64, 0, 0, 1'b0);

      repeat (1000) begin
         pt = {$urandom, $urandom};
         k  = {16'($urandom), $urandom, $urandom};
         ct = model_enc(pt, k);
         run_req(ct, k, pt, 0, 0, 1'b0);
      end

      repeat (5) @(posedge clock);
      #1;
      check("scoreboard_empty", 80'(exp_q.size()), 80'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/present_decrypt_core.md
Name: present_decrypt_core

Overview:
Iterative PRESENT-80 decryption engine, the inverse of the encryption datapath: inverse permutation layer, inverse S-box layer, and round-key removal, one round per clock. It accepts a 64-bit ciphertext and an 80-bit key through a start handshake. It first runs the key schedule forward to K32, then unwinds it backward while decrypting. It sits beside the encryption core and presents plaintext through a valid/ack handshake.

Parameters:
ROUNDS, 31, number of full PRESENT rounds (fixed by the algorithm; exposed only for the bench's round-count checks)
KEY_W, 80, key width (only 80 is supported)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable_in  input  1  start request; sampled only while ready_out=1
ciphertext  input  64  ciphertext block, captured with enable_in
key  input  80  cipher key K1, captured with enable_in
ready_out  output  1  high in IDLE only; new request can be accepted
valid_out  output  1  plaintext valid; held until ack_in
ack_in  input  1  consumer accepts plaintext
plaintext  output  64  decrypted block; meaningful only while valid_out=1
busy  output  1  high in KEYFWD, WHITEN and DECR

Behaviour:
- Reset values:
  - ready_out=1, valid_out=0, busy=0, plaintext=0.
  - Internal state register, key register and round counter all 0.
  - FSM goes to IDLE.
  - Reset wins over every other input in the same cycle.
- FSM states: IDLE, KEYFWD, WHITEN, DECR, DONE.
- IDLE, when enable_in=1 at edge E0:
  - Latch ciphertext into the state register and key into the key register.
  - Counter <= 1; go to KEYFWD.
- KEYFWD, edges E1..E31, one per counter value i=1..31:
  - key <= rotl(key,61).
  - key[79:76] <= S(key[79:76]).
  - key[19:15] ^= i (5-bit).
  - Counter increments.
  - After i=31 the key register holds K32; go to WHITEN.
- WHITEN, edge E32:
  - state ^= key[79:16].
  - Counter <= 31; go to DECR.
- DECR, edges E33..E63, counter i=31 down to 1, each edge:
  - knext = inverse step of key: key[19:15] ^= i, then key[79:76] = Sinv(key[79:76]), then rotr(key,61).
  - key <= knext.
  - state <= SinvLayer(PinvLayer(state)) ^ knext[79:16].
  - PinvLayer: out bit j = in bit P(j), with P(j)=16*(j mod 4)+floor(j/4) for j<63 and P(63)=63.
  - After i=1: plaintext <= result; go to DONE.
- DONE:
  - valid_out=1 and plaintext stable.
  - valid_out first seen high after edge E63, i.e. fixed latency 63 cycles from acceptance.
  - On ack_in=1: valid_out<=0, go to IDLE.
- Handshake and boundary conditions:
  - enable_in outside IDLE is ignored, with no queuing.
  - ack_in outside DONE is ignored.
  - ack_in and enable_in together in DONE: only the ack is consumed; enable_in must be re-asserted in IDLE.
  - The minimum cycle between requests is 65 clocks (acceptance, 63, ack, back in IDLE).
  - Counter widths are 5 bits, with no wrap inside a run; the counter is compared explicitly against 31 and 1.
  - Changes on ciphertext/key after acceptance have no effect.
  - reset mid-run aborts immediately, with no valid_out pulse.
  - plaintext holds its value after ack until the next completion (plaintext is not cleared).

Decomposition:
- Shared include file present_defs.vh:
  - 4-bit S-box and inverse S-box tables as functions.
  - FSM state encodings.
  - ROUNDS and KEY_W constants.
  - It is shared with the encryption core.
- One sub-module, present_key_step: combinational forward/inverse 80-bit key-schedule step, selected by a dir input with counter input.
- Inverse pLayer and inverse S-box layer stay inline as functions in the core.

Test Plan:
1. Reset, then ciphertext=5579C1387B228445, key=0 -> after 63 cycles valid_out=1, plaintext=0000000000000000.
2. ciphertext=E72C46C0F5945049, key=FFFF_FFFFFFFFFFFFFFFF -> plaintext=0000000000000000; busy high exactly 63 cycles.
3. ciphertext=A112FFC72F68417B with key=0, then back-to-back ciphertext=3333DCD3213210D2 with key=all-ones -> plaintexts FFFFFFFFFFFFFFFF and FFFFFFFFFFFFFFFF.
4. enable_in pulsed during DECR with different ciphertext -> ignored; result of the first request unchanged; ack_in held low 10 cycles keeps valid_out and plaintext stable; ack_in+enable_in same cycle in DONE -> back to IDLE, no new run.
5. reset asserted at cycle 40 of a run -> next edge ready_out=1, busy=0, valid_out=0; no valid pulse follows; a fresh request afterward decrypts correctly.
6. Random ciphertext/key pairs checked against the team's reference model encrypt-then-decrypt round trip (1000 vectors) -> all plaintexts match.
